// File: rtl/qtwos_comp_pipe.sv
// Two-stage valid/ready pipeline that converts N-bit words between two's complement and
// sign-magnitude forms, flags saturated results and counts delivered saturations.
module qtwos_comp_pipe #(
   parameter int N     = 16,
   parameter int Q     = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic             out_ovf,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             ovf_clr
);

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_NEG   = 2'b01,
      MODE_SM2TC = 2'b10,
      MODE_TC2SM = 2'b11
   } mode_e;

   localparam logic [N-1:0]     ONE_N   = N'(1);
   localparam logic [N-1:0]     MIN_N   = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0]     MAX_N   = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]     ONES_N  = {N{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Q only documents the fixed-point interpretation; it is range-checked here and
   // otherwise has no effect on the bit-level arithmetic.
   if (N < 4 || Q < 0 || Q >= N || CNT_W < 1) begin : g_param_check
      $error("qtwos_comp_pipe: illegal parameters N=%0d Q=%0d CNT_W=%0d", N, Q, CNT_W);
   end

   // Handshake: a word moves on any edge where valid & ready are both high. The whole
   // pipe advances together on en = !out_valid | out_ready, and in_ready is exactly en,
   // so when the output is stalled every stage holds its data and valid bit.
   logic           en;

   logic           s1_valid_q, s1_valid_d;
   logic [N-1:0]   s1_data_q,  s1_data_d;
   mode_e          s1_mode_q,  s1_mode_d;

   logic           s2_valid_q, s2_valid_d;
   logic [N-1:0]   s2_data_q,  s2_data_d;
   logic           s2_ovf_q,   s2_ovf_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]   neg_x;
   logic [N-1:0]   mag;
   logic [N-1:0]   neg_mag;
   logic [N-1:0]   conv_data;
   logic           conv_ovf;

   assign en        = !s2_valid_q || out_ready;
   assign in_ready  = en;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_ovf   = s2_ovf_q;
   assign ovf_count = cnt_q;

   // Full-width inversion keeps the negation exact for every operand except the minimum.
   always_comb begin
      neg_x     = ~s1_data_q + ONE_N;
      mag       = {1'b0, s1_data_q[N-2:0]};
      neg_mag   = ~mag + ONE_N;
      conv_data = s1_data_q;
      conv_ovf  = 1'b0;
      case (s1_mode_q)
         MODE_PASS: begin
            conv_data = s1_data_q;
         end
         MODE_NEG: begin
            if (s1_data_q == MIN_N) begin
               conv_data = MAX_N;
               conv_ovf  = 1'b1;
            end else begin
               conv_data = neg_x;
            end
         end
         MODE_SM2TC: begin
            conv_data = s1_data_q[N-1] ? neg_mag : mag;
         end
         MODE_TC2SM: begin
            if (s1_data_q == MIN_N) begin
               conv_data = ONES_N;
               conv_ovf  = 1'b1;
            end else if (s1_data_q[N-1]) begin
               conv_data = {1'b1, neg_x[N-2:0]};
            end else begin
               conv_data = s1_data_q;
            end
         end
         default: begin
            conv_data = s1_data_q;
         end
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_mode_d  = s1_mode_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_ovf_d   = s2_ovf_q;
      if (en) begin
         s1_valid_d = in_valid;
         s2_valid_d = s1_valid_q;
         if (in_valid) begin
            s1_data_d = in_data;
            s1_mode_d = mode_e'(in_mode);
         end
         if (s1_valid_q) begin
            s2_data_d = conv_data;
            s2_ovf_d  = conv_ovf;
         end
      end
   end

   // Clear wins over a same-cycle saturated delivery.
   always_comb begin
      cnt_d = cnt_q;
      if (ovf_clr) begin
         cnt_d = '0;
      end else if (s2_valid_q && out_ready && s2_ovf_q && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= MODE_PASS;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_ovf_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_ovf_q   <= s2_ovf_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: doc/qtwos_comp_pipe.md
QTWOS_COMP_PIPE -- requirements
Module: qtwos_comp_pipe

Interface
REQ-001 SHALL have parameter N, default 16, total word width in bits (N >= 4).
REQ-002 SHALL have parameter Q, default 8, fractional bit count (0 <= Q < N); it is carried for Q-format consistency and does not change the arithmetic.
REQ-003 SHALL have parameter CNT_W, default 8, width of the overflow event counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_data/in_mode are valid this cycle.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_data  input  N  operand.
REQ-009 in_mode  input  2  00 pass, 01 negate, 10 sign-magnitude to two's complement, 11 two's complement to sign-magnitude.
REQ-010 out_valid  output  1  out_data/out_ovf are valid.
REQ-011 out_ready  input  1  downstream consumes the output this cycle.
REQ-012 out_data  output  N  converted result.
REQ-013 out_ovf  output  1  result was saturated.
REQ-014 ovf_count  output  CNT_W  saturating count of delivered saturated results.
REQ-015 ovf_clr  input  1  synchronous clear of ovf_count.

Function
REQ-016 SHALL be a two-stage pipeline: stage 1 registers operand and mode; stage 2 registers result and flag.
REQ-017 Advance enable en = !out_valid | out_ready; SHALL drive in_ready = en combinationally.
REQ-018 A transfer occurs when in_valid & in_ready; on en, stage-1 valid <= in_valid, stage-2 valid <= stage-1 valid.
REQ-019 When en = 0, both stages SHALL hold data and valid unchanged (no loss, no duplication).
REQ-020 Latency SHALL be exactly 2 cycles from an accepted input to out_valid, with no downstream stall.
REQ-021 With out_ready held at 1, throughput SHALL be one result per cycle; bubbles propagate as out_valid = 0.
REQ-022 Mode 00 SHALL output in_data unchanged, with ovf = 0.
REQ-023 Mode 01 SHALL output (~x + 1) mod 2^N.
REQ-024 Mode 01 with x = 100..0 SHALL output 011..1, with ovf = 1.
REQ-025 Mode 10 SHALL treat bit N-1 as sign and bits N-2:0 as magnitude.
REQ-026 Mode 10 with sign 0 SHALL output the magnitude zero-extended.
REQ-027 Mode 10 with sign 1 SHALL output the N-bit two's complement negation of the magnitude.
REQ-028 Mode 10 with negative zero (100..0) SHALL output 0, with ovf = 0.
REQ-029 Mode 11 with a non-negative x SHALL output x unchanged.
REQ-030 Mode 11 with a negative x SHALL output sign 1 and magnitude = negation of x in N-1 bits.
REQ-031 Mode 11 with x = 100..0 SHALL output 111..1, with ovf = 1.
REQ-032 All arithmetic SHALL be performed internally at N bits, never narrower than the operand, so the bit inversion is of the full word.
REQ-033 ovf_count SHALL increment by 1 on each output transfer (out_valid & out_ready) with out_ovf = 1.
REQ-034 ovf_count SHALL saturate at 2^CNT_W-1.
REQ-035 ovf_clr SHALL take priority over a same-cycle increment, leaving ovf_count = 0.
REQ-036 out_data and out_ovf SHALL be don't-care when out_valid = 0; they SHALL still be deterministic after reset.

Reset
REQ-037 While rst_n = 0, SHALL force both valid flags, out_data, out_ovf, stage-1 registers and ovf_count to 0 immediately, independent of clk.
REQ-038 During reset, in_ready SHALL follow REQ-017 (= 1, since out_valid = 0).
REQ-039 Reset asserted mid-operation SHALL discard all in-flight data; no output transfer occurs for those items after release.
REQ-040 The first rising clk edge with rst_n = 1 SHALL be able to accept an input.

Verification
REQ-041 N=16, out_ready=1: mode 01 inputs 0x0001, 0x8000, 0x0000 on consecutive cycles -> outputs 0xFFFF/ovf0, 0x7FFF/ovf1, 0x0000/ovf0, 2 cycles later; ovf_count = 1.
REQ-042 Mode 10 inputs 0x8005, 0x8000, 0x0005 -> 0xFFFB, 0x0000, 0x0005, all ovf 0. Mode 11 inputs 0xFFFB, 0x8000 -> 0x8005/ovf0, 0xFFFF/ovf1.
REQ-043 Back-pressure: 4 items sent, out_ready low 3 cycles after the first output -> out_valid and out_data held stable; in_ready = 0; all 4 items delivered in order with none lost or duplicated.
REQ-044 CNT_W=2: 5 saturating results -> ovf_count 1,2,3,3,3; ovf_clr together with a saturating transfer -> ovf_count = 0.
REQ-045 Assert rst_n low asynchronously with 2 items in flight -> out_valid = 0 and ovf_count = 0 before the next clk edge; after release, no stale output appears and a new item emerges in 2 cycles.
REQ-046 Random sweep of N in {4, 16, 32} against a reference model -> zero mismatches, including all corner cases 0, 1, 100..0, 011..1 and 11..1.
